// File: rtl/spi_rb_burst_bridge.sv
// SPI-to-regbank burst bridge: turns decoded SPI commands into write/read
// bursts on one of NB register-bank channels.
// Optional feature macro: SPI_RB_BURST_WRAP_EN. When it is defined, an
// auto-incrementing address wraps from all-ones to zero and the burst goes on.
// When it is undefined, the access at all-ones completes and the next advance
// raises o_err and ends the burst.
module spi_rb_burst_bridge #(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 8,
  parameter int unsigned NB         = 2,
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned RD_TIMEOUT = 15,
  localparam int unsigned BW        = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  input  logic             i_cmd_to_register,
  input  logic             i_cmd_write,
  input  logic             i_cmd_incr,
  input  logic             i_cmd_reset_spi,
  input  logic [BW-1:0]    i_cmd_bank,
  input  logic [AW-1:0]    i_cmd_addr,
  input  logic             i_spi_req,
  input  logic             i_spi_rx_valid,
  input  logic [DW-1:0]    i_spi_rx_data,
  output logic [DW-1:0]    o_spi_tx_data,
  output logic             o_spi_tx_valid,
  output logic [NB-1:0]    o_wr_en,
  output logic [NB-1:0]    o_rd_en,
  output logic [AW-1:0]    o_addr,
  output logic [DW-1:0]    o_wr_data,
  input  logic [NB-1:0]    i_rd_valid,
  input  logic [NB*DW-1:0] i_rd_data,
  output logic             o_busy,
  output logic             o_err
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);
`ifdef SPI_RB_BURST_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            incr_q, incr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_out_q, rd_out_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [NB-1:0]   wr_en_q, wr_en_d;
  logic [NB-1:0]   rd_en_q, rd_en_d;
  logic [AW-1:0]   oaddr_q, oaddr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic            cmd_bank_ok;
  logic            sel_rd_valid;
  logic [DW-1:0]   sel_rd_data;
  logic [AW-1:0]   addr_inc;
  logic            addr_top;
  logic [NB-1:0]   bank_sel;

  assign addr_inc = addr_q + AW'(1);
  assign addr_top = &addr_q;
  assign bank_sel = NB'(1) << bank_q;

  // Command bank validity and read-return mux for the latched channel
  always_comb begin
    cmd_bank_ok  = 1'b0;
    sel_rd_valid = 1'b0;
    sel_rd_data  = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (BW'(k) == i_cmd_bank) cmd_bank_ok = 1'b1;
      if (BW'(k) == bank_q) begin
        sel_rd_valid = i_rd_valid[k];
        sel_rd_data  = i_rd_data[k*DW +: DW];
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    addr_d     = addr_q;
    incr_d     = incr_q;
    cnt_d      = cnt_q;
    rd_out_d   = rd_out_q;
    tmo_d      = tmo_q;
    oaddr_d    = oaddr_q;
    wr_data_d  = wr_data_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = '0;
    rd_en_d    = '0;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;

    if (i_cmd_reset_spi) begin
      state_d  = ST_IDLE;
      rd_out_d = 1'b0;
      tmo_d    = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid && i_cmd_to_register) begin
            bank_d = i_cmd_bank;
            addr_d = i_cmd_addr;
            incr_d = i_cmd_incr;
            cnt_d  = '0;
            if (!cmd_bank_ok) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else if (i_cmd_write) begin
              state_d = ST_WRITE;
            end else begin
              // Prefetch the first word so it is ready for the first SPI request
              state_d  = ST_READ;
              rd_en_d  = NB'(1) << i_cmd_bank;
              oaddr_d  = i_cmd_addr;
              rd_out_d = 1'b1;
              tmo_d    = '0;
            end
          end
        end

        ST_WRITE: begin
          if (i_spi_rx_valid) begin
            wr_en_d   = bank_sel;
            wr_data_d = i_spi_rx_data;
            oaddr_d   = addr_q;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_d == CW'(MAX_BURST)) begin
              state_d = ST_DONE;
            end else if (incr_q) begin
              // The advance that follows a write at all-ones is the one that fails
              if (addr_top && !WRAP_EN) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end else begin
                addr_d = addr_inc;
              end
            end
          end
        end

        ST_READ: begin
          if (rd_out_q) begin
            if (sel_rd_valid) begin
              tx_valid_d = 1'b1;
              tx_data_d  = sel_rd_data;
              rd_out_d   = 1'b0;
              tmo_d      = '0;
            end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
              tx_valid_d = 1'b1;
              tx_data_d  = '0;
              err_d      = 1'b1;
              rd_out_d   = 1'b0;
              tmo_d      = '0;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
            if (i_spi_req) err_d = 1'b1;
          end else if (i_spi_req) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(MAX_BURST)) begin
              state_d = ST_DONE;
            end else if (incr_q && addr_top && !WRAP_EN) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              addr_d   = incr_q ? addr_inc : addr_q;
              oaddr_d  = incr_q ? addr_inc : addr_q;
              rd_en_d  = bank_sel;
              rd_out_d = 1'b1;
              tmo_d    = '0;
            end
          end
        end

        ST_DONE: begin
        end

        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      incr_q     <= 1'b0;
      cnt_q      <= '0;
      rd_out_q   <= 1'b0;
      tmo_q      <= '0;
      wr_en_q    <= '0;
      rd_en_q    <= '0;
      oaddr_q    <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      incr_q     <= incr_d;
      cnt_q      <= cnt_d;
      rd_out_q   <= rd_out_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      oaddr_q    <= oaddr_d;
      wr_data_q  <= wr_data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign o_spi_tx_data  = tx_data_q;
  assign o_spi_tx_valid = tx_valid_q;
  assign o_wr_en        = wr_en_q;
  assign o_rd_en        = rd_en_q;
  assign o_addr         = oaddr_q;
  assign o_wr_data      = wr_data_q;
  assign o_busy         = busy_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_spi_rb_burst_bridge.sv
// Scoreboard bench for spi_rb_burst_bridge: drivers push expected bus beats,
// TX words and error counts; an independent monitor checks what the DUT emits.
`timescale 1ns/1ps
module tb_spi_rb_burst_bridge;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 8;
  localparam int unsigned NB   = 3;
  localparam int unsigned BW   = 2;
  localparam int unsigned MAXB = 4;
  localparam int unsigned RDT  = 15;
  localparam int unsigned RDW  = NB * DW;
  localparam int          TMO  = 99;
`ifdef SPI_RB_BURST_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_cmd_valid, i_cmd_to_register, i_cmd_write, i_cmd_incr, i_cmd_reset_spi;
  logic [BW-1:0]    i_cmd_bank;
  logic [AW-1:0]    i_cmd_addr;
  logic             i_spi_req, i_spi_rx_valid;
  logic [DW-1:0]    i_spi_rx_data;
  logic [DW-1:0]    o_spi_tx_data;
  logic             o_spi_tx_valid;
  logic [NB-1:0]    o_wr_en, o_rd_en;
  logic [AW-1:0]    o_addr;
  logic [DW-1:0]    o_wr_data;
  logic [NB-1:0]    i_rd_valid;
  logic [RDW-1:0]   i_rd_data;
  logic             o_busy, o_err;

  spi_rb_burst_bridge #(.DW(DW), .AW(AW), .NB(NB), .MAX_BURST(MAXB), .RD_TIMEOUT(RDT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .i_cmd_to_register(i_cmd_to_register),
    .i_cmd_write(i_cmd_write), .i_cmd_incr(i_cmd_incr), .i_cmd_reset_spi(i_cmd_reset_spi),
    .i_cmd_bank(i_cmd_bank), .i_cmd_addr(i_cmd_addr),
    .i_spi_req(i_spi_req), .i_spi_rx_valid(i_spi_rx_valid), .i_spi_rx_data(i_spi_rx_data),
    .o_spi_tx_data(o_spi_tx_data), .o_spi_tx_valid(o_spi_tx_valid),
    .o_wr_en(o_wr_en), .o_rd_en(o_rd_en), .o_addr(o_addr), .o_wr_data(o_wr_data),
    .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [NB-1:0] en;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         exp_wr[$];
  beat_t         exp_rd[$];
  logic [DW-1:0] exp_tx[$];
  int            exp_err = 0;
  int            obs_err = 0;
  int            n_vec   = 0;
  int            n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard
  always @(negedge i_clk) begin
    beat_t         e;
    logic [DW-1:0] t;
    if (i_rst_n) begin
      if (|o_wr_en || |o_rd_en)
        chk("strobe_exclusive", 64'(|o_wr_en && |o_rd_en), 64'(0));
      if (|o_wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 64'({o_wr_en, o_addr, o_wr_data}), 64'(0));
        else begin
          e = exp_wr.pop_front();
          chk("wr_beat", 64'({o_wr_en, o_addr, o_wr_data}), 64'(e));
        end
      end
      if (|o_rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 64'({o_rd_en, o_addr}), 64'(0));
        else begin
          e = exp_rd.pop_front();
          chk("rd_beat", 64'({o_rd_en, o_addr, DW'(0)}), 64'(e));
        end
      end
      if (o_spi_tx_valid) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", 64'({1'b1, o_spi_tx_data}), 64'(0));
        else begin
          t = exp_tx.pop_front();
          chk("tx_data", 64'(o_spi_tx_data), 64'(t));
        end
      end
      if (o_err) obs_err++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_cmd_valid = 1'b0; i_cmd_to_register = 1'b0; i_cmd_write = 1'b0; i_cmd_incr = 1'b0;
    i_cmd_bank = '0; i_cmd_addr = '0; i_spi_req = 1'b0; i_spi_rx_valid = 1'b0;
    i_spi_rx_data = '0; i_rd_valid = '0; i_rd_data = '0;
  endtask

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Words reachable from addr before an increment would pass all-ones
  function automatic int room_of(input bit inc, input int addr);
    return (inc && !WRAP) ? ((1 << AW) - addr) : (1 << 20);
  endfunction

  task automatic send_cmd(input bit wr, input bit inc, input int bank, input int addr);
    i_cmd_valid = 1'b1; i_cmd_to_register = 1'b1; i_cmd_write = wr; i_cmd_incr = inc;
    i_cmd_bank = BW'(bank); i_cmd_addr = AW'(addr);
    tick();
    i_cmd_valid = 1'b0; i_cmd_to_register = 1'b0;
    chk("busy_after_cmd", 64'(o_busy), 64'(1));
  endtask

  task automatic pulse_req();
    i_spi_req = 1'b1;
    i_spi_rx_valid = 1'($urandom_range(0, 1));
    tick();
    i_spi_req = 1'b0; i_spi_rx_valid = 1'b0;
  endtask

  task automatic finish_scn(input string nm);
    repeat (3) tick();
    i_cmd_reset_spi = 1'b1;
    tick();
    i_cmd_reset_spi = 1'b0;
    chk({nm, "_busy_after_abort"}, 64'(o_busy), 64'(0));
    tick();
    chk({nm, "_wr_missing"}, 64'(exp_wr.size()), 64'(0));
    chk({nm, "_rd_missing"}, 64'(exp_rd.size()), 64'(0));
    chk({nm, "_tx_missing"}, 64'(exp_tx.size()), 64'(0));
    chk({nm, "_err_count"}, 64'(obs_err), 64'(exp_err));
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
    obs_err = 0; exp_err = 0;
  endtask

  task automatic do_write(input string nm, input int bank, input int addr, input bit inc,
                          input int n, input int base, input int step, input bit noise);
    int            room, k;
    logic [NB-1:0] oh;
    beat_t         b;
    room = room_of(inc, addr);
    oh = NB'(1) << bank;
    if (bank >= int'(NB)) exp_err++;
    else begin
      k = min3(n, MAXB, room);
      for (int i = 0; i < k; i++) begin
        b.en = oh; b.a = AW'(addr + (inc ? i : 0)); b.d = DW'(base + i * step);
        exp_wr.push_back(b);
      end
      if (room < int'(MAXB) && n >= room) exp_err++;
    end
    send_cmd(1'b1, inc, bank, addr);
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        repeat ($urandom_range(0, 2)) begin
          i_spi_req = 1'($urandom_range(0, 1));
          i_rd_valid = NB'($urandom);
          i_cmd_valid = 1'($urandom_range(0, 1)); i_cmd_to_register = 1'b1; i_cmd_write = 1'b0;
          tick();
          idle_in();
        end
      end
      i_spi_rx_valid = 1'b1; i_spi_rx_data = DW'(base + i * step);
      tick();
      i_spi_rx_valid = 1'b0;
    end
    finish_scn(nm);
  endtask

  // Regbank responder for one read: wait for the strobe, answer after lat cycles
  task automatic serve_read(input int bank, input int lat);
    bit            seen;
    int unsigned   t0;
    int            want_lat;
    logic [DW-1:0] d;
    logic [NB-1:0] oh;
    oh = NB'(1) << bank;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (|o_rd_en) seen = 1'b1;
      else tick();
    end
    chk("rd_issued", 64'(seen), 64'(1));
    if (!seen) return;
    t0 = cyc;
    if (lat == TMO) begin
      exp_tx.push_back('0);
      exp_err++;
      want_lat = int'(RDT);
    end else begin
      d = DW'($urandom);
      exp_tx.push_back(d);
      want_lat = lat + 1;
      for (int k = 0; k < lat; k++) begin
        if (k == 0 && $urandom_range(0, 2) == 0) begin
          i_spi_req = 1'b1;
          exp_err++;
        end
        i_rd_valid = NB'($urandom) & ~oh;
        tick();
        i_spi_req = 1'b0; i_rd_valid = '0;
      end
      i_rd_data = RDW'({$urandom, $urandom});
      i_rd_data[bank*DW +: DW] = d;
      i_rd_valid = oh | (NB'($urandom) & ~oh);
      tick();
      i_rd_valid = '0;
    end
    seen = 1'b0;
    for (int k = 0; k < int'(RDT) + 5 && !seen; k++) begin
      if (o_spi_tx_valid) seen = 1'b1;
      else tick();
    end
    chk("tx_seen", 64'(seen), 64'(1));
    if (seen) chk("tx_latency", 64'(cyc - t0), 64'(want_lat));
  endtask

  task automatic do_read(input string nm, input int bank, input int addr, input bit inc,
                         input int nreq, input int lat_fix);
    int            room, r, sent, lat;
    logic [NB-1:0] oh;
    beat_t         b;
    room = room_of(inc, addr);
    oh = NB'(1) << bank;
    if (bank >= int'(NB)) begin
      r = 0;
      exp_err++;
    end else begin
      r = min3(nreq + 1, MAXB, room);
      if (room < int'(MAXB) && nreq >= room) exp_err++;
    end
    for (int i = 0; i < r; i++) begin
      b.en = oh; b.a = AW'(addr + (inc ? i : 0)); b.d = '0;
      exp_rd.push_back(b);
    end
    send_cmd(1'b0, inc, bank, addr);
    sent = 0;
    for (int i = 0; i < r; i++) begin
      if (lat_fix >= 0) lat = lat_fix;
      else lat = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, 3));
      serve_read(bank, lat);
      if (sent < nreq) begin
        repeat ($urandom_range(0, 2)) tick();
        pulse_req();
        sent++;
      end
    end
    while (sent < nreq) begin
      pulse_req();
      sent++;
    end
    finish_scn(nm);
  endtask

  initial begin
    beat_t b;
    idle_in();
    i_cmd_reset_spi = 1'b0;
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_outputs", 64'({o_wr_en, o_rd_en, o_addr, o_wr_data, o_spi_tx_data,
                              o_spi_tx_valid, o_busy, o_err}), 64'(0));
    i_rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 64'({o_wr_en, o_rd_en, o_spi_tx_valid, o_busy, o_err}), 64'(0));

    // Commands not aimed at the regbank are ignored
    i_cmd_valid = 1'b1; i_cmd_to_register = 1'b0; i_cmd_write = 1'b1;
    tick();
    idle_in();
    tick();
    chk("not_register_ignored", 64'(o_busy), 64'(0));

    do_write("req025", 1, 'h10, 1'b1, 2, 'hAAAA, 'h1111, 1'b0);
    do_read ("req026", 0, 'h20, 1'b1, 3, 2);
    do_read ("req027", 0, 'hFF, 1'b1, 1, 1);
    do_read ("req028", 1, 'h33, 1'b1, 0, TMO);
    do_write("req029", 0, 'h05, 1'b0, 5, 'h1357, 'h0101, 1'b0);
    do_write("wr_top", 2, 'hFE, 1'b1, 4, 'h4000, 'h0003, 1'b1);
    do_write("bad_bank", 3, 'h10, 1'b1, 2, 'h2222, 'h0001, 1'b0);

    // Abort coincident with a write word suppresses that strobe
    b.en = 3'b100; b.a = 8'h40; b.d = 16'h1234;
    exp_wr.push_back(b);
    send_cmd(1'b1, 1'b1, 2, 'h40);
    i_spi_rx_valid = 1'b1; i_spi_rx_data = 16'h1234;
    tick();
    i_spi_rx_valid = 1'b0;
    tick();
    i_spi_rx_valid = 1'b1; i_spi_rx_data = 16'h5678; i_cmd_reset_spi = 1'b1;
    tick();
    i_spi_rx_valid = 1'b0; i_cmd_reset_spi = 1'b0;
    chk("req030_no_wr", 64'(o_wr_en), 64'(0));
    chk("req030_busy", 64'(o_busy), 64'(0));
    finish_scn("req030");

    // Hard reset mid-read discards everything, late returns are ignored
    b.en = 3'b001; b.a = 8'h30; b.d = '0;
    exp_rd.push_back(b);
    send_cmd(1'b0, 1'b1, 0, 'h30);
    tick(); tick();
    i_rst_n = 1'b0;
    #1;
    chk("midburst_reset_outputs", 64'({o_wr_en, o_rd_en, o_addr, o_wr_data, o_spi_tx_data,
                                       o_spi_tx_valid, o_busy, o_err}), 64'(0));
    tick(); tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_rd_valid = '1; i_rd_data = RDW'({$urandom, $urandom});
      i_spi_rx_valid = 1'b1; i_spi_req = 1'b1;
      tick();
    end
    idle_in();
    chk("post_reset_idle", 64'(o_busy), 64'(0));
    finish_scn("hard_reset");

    for (int s = 0; s < 40; s++) begin
      int bank, addr, n;
      bit inc, wr;
      bank = int'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      inc  = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : 255 - int'($urandom_range(0, 4));
      n    = int'($urandom_range(0, 6));
      if (wr) do_write("rnd_wr", bank, addr, inc, n, int'($urandom_range(0, 65535)),
                       int'($urandom_range(1, 65535)), 1'b1);
      else    do_read("rnd_rd", bank, addr, inc, n, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_rb_burst_bridge.md
SPI_RB_BURST_BRIDGE -- requirements
Module: spi_rb_burst_bridge

Interface
REQ-001 SHALL have parameter DW, default 16, meaning register/SPI word width.
REQ-002 SHALL have parameter AW, default 8, meaning register address width.
REQ-003 SHALL have parameter NB, default 2, meaning number of regbank channels (>=1); BW = max(1,$clog2(NB)).
REQ-004 SHALL have parameter MAX_BURST, default 64, meaning maximum words per command.
REQ-005 SHALL have parameter RD_TIMEOUT, default 15, meaning cycles to wait for read data.
REQ-006 SHALL have ports, one per line:
- i_clk  in  1  clock; i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  decoded command strobe; i_cmd_to_register  in  1  target is regbank
- i_cmd_write  in  1  1=write burst, 0=read burst; i_cmd_incr  in  1  1=auto-increment, 0=fixed address
- i_cmd_reset_spi  in  1  synchronous abort; i_cmd_bank  in  BW  channel select; i_cmd_addr  in  AW  start address
- i_spi_req  in  1  SPI needs next TX word (pulse); i_spi_rx_valid  in  1  RX word ready (pulse); i_spi_rx_data  in  DW
- o_spi_tx_data  out  DW; o_spi_tx_valid  out  1  TX word strobe
- o_wr_en  out  NB  one-hot write strobe; o_rd_en  out  NB  one-hot read strobe; o_addr  out  AW; o_wr_data  out  DW
- i_rd_valid  in  NB; i_rd_data  in  NB*DW  (channel k at [k*DW +: DW])
- o_busy  out  1  state != IDLE; o_err  out  1  error pulse

Function
REQ-007 SHALL implement FSM IDLE, WRITE, READ, DONE; DONE exits only via i_cmd_reset_spi.
REQ-008 IDLE: i_cmd_valid & i_cmd_to_register SHALL latch bank, addr, incr, clear burst count, go WRITE/READ per i_cmd_write; to_register=0 ignored; i_cmd_valid outside IDLE ignored.
REQ-009 i_cmd_bank >= NB SHALL pulse o_err one cycle and go DONE, no bus access.
REQ-010 READ entry SHALL issue prefetch: o_rd_en[bank]=1 one cycle after acceptance, o_addr=start.
REQ-011 i_rd_valid[bank] SHALL produce o_spi_tx_valid=1, o_spi_tx_data=channel data, next cycle; other channels' valids ignored.
REQ-012 Each i_spi_req in READ with no read outstanding SHALL advance address (if incr), count word, issue next o_rd_en the following cycle.
REQ-013 i_spi_req while read outstanding SHALL be dropped with o_err pulse.
REQ-014 No i_rd_valid within RD_TIMEOUT cycles of o_rd_en SHALL emit o_spi_tx_valid with data 0, pulse o_err, clear outstanding.
REQ-015 WRITE: each i_spi_rx_valid SHALL produce o_wr_en[bank]=1, o_wr_data=i_spi_rx_data, o_addr=current, next cycle; address advances after (if incr); i_spi_req ignored.
REQ-016 i_spi_rx_valid in READ, and i_spi_req/i_spi_rx_valid in IDLE/DONE, SHALL be ignored.
REQ-017 Burst count reaching MAX_BURST SHALL go DONE after that word's access; further strobes ignored.
REQ-018 Address increment at all-ones SHALL follow REQ-024.
REQ-019 Strobes o_wr_en, o_rd_en, o_spi_tx_valid, o_err SHALL be single-cycle; at most one of o_wr_en/o_rd_en per cycle.
REQ-020 i_cmd_reset_spi SHALL take priority over all inputs in the same cycle: IDLE next cycle, outstanding read and counters cleared, pending strobes suppressed, later i_rd_valid ignored until new read issued.

Reset
REQ-021 i_rst_n low SHALL asynchronously force IDLE and all outputs 0 (o_addr, o_wr_data, o_spi_tx_data included).
REQ-022 Reset mid-burst SHALL discard all state; no strobe after release without new command.
REQ-023 Internal address, bank, burst and timeout counters SHALL reset to 0.

Configuration
REQ-024 Macro SPI_RB_BURST_WRAP_EN: defined -> address all-ones increments to 0, burst continues; undefined -> access at all-ones completes, o_err pulses on next attempted advance, FSM goes DONE.

Verification
REQ-025 Write burst bank 1, addr 0x10, incr, rx 0xAAAA,0xBBBB -> o_wr_en=2'b10 at 0x10/0xAAAA then 0x11/0xBBBB.
REQ-026 Read bank 0, addr 0x20, incr, 3 req pulses, rd latency 2 -> o_rd_en at 0x20,0x21,0x22,0x23; tx_valid with each channel-0 datum.
REQ-027 Read addr 0xFF, one req -> WRAP_EN: next read 0x00; else o_err, DONE, no second read.
REQ-028 Read with i_rd_valid held 0 -> after 15 cycles tx_valid data 0x0000, o_err pulse.
REQ-029 Fixed mode (incr=0), MAX_BURST=4, 5 rx pulses, addr 0x05 -> 4 writes at 0x05, DONE, 5th ignored.
REQ-030 i_cmd_reset_spi coincident with i_rx_valid mid-write -> no o_wr_en, IDLE next cycle, o_busy=0.
